// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word geometry
// and the data value returned for stores and rejected accesses.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState_e;

    localparam int          WORD_BYTES = 4;
    localparam int          ADDR_LSB   = $clog2(WORD_BYTES);
    localparam logic [31:0] ZERO_DATA  = 32'h0;

endpackage

// File: rtl/dmem_ram_array.sv
// Single-port synchronous word RAM. A read returns the word as it was before a
// write that happens on the same edge.
module dmem_ram_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store port with LATENCY wait states.
// Optional misaligned-access rejection is built when DMEM_ALIGN_CHECK_EN is defined.
//
// state | meaning
// IDLE  | ready; a valid request is accepted and the wait counter loaded
// WAIT  | counting down wait states; request held
// RESP  | one-cycle response; RAM was accessed on the edge entering this state
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int AW      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_m
);

    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    dmemState_e    state;
    logic [CW-1:0] waitCnt;
    logic          capWe;
    logic [AW+1:0] capAddr;
    logic [31:0]   capWdata;
    logic          respZero;
    logic [31:0]   holdData;

    logic          accept;
    logic          goResp;
    logic          accWe;
    logic [AW+1:0] accAddr;
    logic [31:0]   accWdata;
    logic          misaligned;
    logic          ramWe;
    logic [31:0]   ramRdata;
    logic          addrUnused;

    assign accept = (state == IDLE) && req_valid;
    assign goResp = (accept && (LATENCY == 0)) || ((state == WAIT) && (waitCnt == CW'(1)));

    // With zero wait states the RAM is accessed on the accept edge itself,
    // so the live request must reach the RAM before it has been captured.
    assign accWe    = (state == IDLE) ? req_we             : capWe;
    assign accAddr  = (state == IDLE) ? req_addr[AW+1:0]   : capAddr;
    assign accWdata = (state == IDLE) ? req_wdata          : capWdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (accAddr[ADDR_LSB-1:0] != '0);
`else
    assign misaligned = 1'b0;
`endif

    assign addrUnused = ^{req_addr[31:AW+2], accAddr[ADDR_LSB-1:0]};

    assign ramWe = reset && goResp && accWe && !misaligned;

    dmem_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ramWe),
        .addr  (accAddr[AW+1:ADDR_LSB]),
        .wdata (accWdata),
        .rdata (ramRdata)
    );

    assign req_ready  = reset && (state == IDLE);
    assign stall_m    = reset && (accept || (state == WAIT));
    assign resp_rdata = (state == RESP) ? (respZero ? ZERO_DATA : ramRdata) : holdData;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            respZero   <= 1'b0;
            holdData   <= ZERO_DATA;
        end else begin
            resp_valid <= goResp;
            resp_err   <= goResp && misaligned;
            if (goResp) begin
                respZero <= accWe || misaligned;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        capWe    <= req_we;
                        capAddr  <= req_addr[AW+1:0];
                        capWdata <= req_wdata;
                        waitCnt  <= CW'(LATENCY);
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - CW'(1);
                    if (waitCnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    holdData <= resp_rdata;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
